// File: rtl/instr_mem_pkg.sv
// Shared types and defaults for the instruction memory fetch path.
// Imported by the fetch stage and the memory itself.
package instr_mem_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned DEPTH_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE,
    SECOND,
    RESP
  } fetch_state_e;

  function automatic logic [7:0] byte_off(
    input logic [7:0]  addr_lo,
    input int unsigned off_w
  );
    logic [7:0] mask;
    mask = ~(8'hFF << off_w);
    return addr_lo & mask;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word RAM: one synchronous read port, one byte-enabled write port.
// Same-edge read of a word being written returns the old contents.
module imem_array #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           rd_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
  output logic [XLEN-1:0]                rd_data,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
  input  logic [XLEN/8-1:0]              wr_be,
  input  logic [XLEN-1:0]                wr_data
);

  localparam int unsigned BYTES = XLEN / 8;

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [XLEN-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem_q[rd_idx];
    end
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_mem_fetch.sv
// Instruction memory with valid/ready fetch handshake, misaligned
// two-word assembly, fault reporting and a debug load port.
module instr_mem_fetch
  import instr_mem_pkg::*;
#(
  parameter int unsigned XLEN             = XLEN_DEF,
  parameter int unsigned DEPTH_WORDS      = DEPTH_DEF,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_instr,
  output logic              resp_fault,
  input  logic              flush,
  input  logic              dbg_wr_en,
  input  logic [XLEN-1:0]   dbg_addr,
  input  logic [XLEN-1:0]   dbg_wdata,
  input  logic [XLEN/8-1:0] dbg_be
);

  localparam int unsigned BYTES = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned HI    = OFF_W + IDX_W;

  fetch_state_e     state_q, state_d;
  logic             fault_q, fault_d;
  logic             mis_q, mis_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [IDX_W-1:0] sec_idx_q, sec_idx_d;
  logic [XLEN-1:0]  w0_q, w0_d;

  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic             req_misal;
  logic             req_fault;
  logic             accept;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic [XLEN-1:0]  rd_data;
  logic             dbg_ok;
  logic [XLEN-1:0]  spliced;

  assign req_idx   = req_addr[OFF_W +: IDX_W];
  assign req_off   = OFF_W'(byte_off(req_addr[7:0], OFF_W));
  assign req_misal = req_off != '0;
  assign req_fault = ((req_addr >> HI) != '0)
                  || (req_misal && (!ALLOW_MISALIGNED
                  || req_idx == IDX_W'(DEPTH_WORDS - 1)));

  assign req_ready = !dbg_wr_en && !flush
                  && (state_q == IDLE
                  || (state_q == RESP && resp_ready));
  assign accept    = req_valid && req_ready;

  assign rd_en  = (accept && !req_fault)
               || (state_q == SECOND && !flush);
  assign rd_idx = (state_q == SECOND) ? sec_idx_q : req_idx;
  assign dbg_ok = dbg_wr_en && ((dbg_addr >> HI) == '0);

  imem_array #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .wr_en   (dbg_ok),
    .wr_idx  (dbg_addr[OFF_W +: IDX_W]),
    .wr_be   (dbg_be),
    .wr_data (dbg_wdata)
  );

  // Second word sits above the first; shift right to the fetch offset.
  assign spliced = XLEN'({rd_data, w0_q} >> {off_q, 3'b000});

  assign resp_valid = state_q == RESP;
  assign resp_fault = resp_valid && fault_q;
  assign resp_instr = (!resp_valid || fault_q) ? '0
                    : (mis_q ? spliced : rd_data);

  always_comb begin
    state_d   = state_q;
    fault_d   = fault_q;
    mis_d     = mis_q;
    off_d     = off_q;
    sec_idx_d = sec_idx_q;
    w0_d      = w0_q;
    if (flush) begin
      state_d = IDLE;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            fault_d   = req_fault;
            mis_d     = req_misal && !req_fault;
            off_d     = req_off;
            sec_idx_d = req_idx + IDX_W'(1);
            state_d   = (req_misal && !req_fault) ? SECOND : RESP;
          end else if (state_q == RESP && resp_ready) begin
            state_d = IDLE;
            fault_d = 1'b0;
          end
        end
        SECOND: begin
          w0_d    = rd_data;
          state_d = RESP;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      fault_q   <= 1'b0;
      mis_q     <= 1'b0;
      off_q     <= '0;
      sec_idx_q <= '0;
      w0_q      <= '0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      mis_q     <= mis_d;
      off_q     <= off_d;
      sec_idx_q <= sec_idx_d;
      w0_q      <= w0_d;
    end
  end

endmodule
